// File: rtl/arith_pkg.sv
// Shared definitions for the ArithmeticOps blocks: FSM state encoding,
// default operand width and a counter-width helper.
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // clog2 with a floor of one bit so a counter always has a legal width
    function automatic int cnt_width(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < w) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add.sv
// Existing 4-bit adder slice: sum/carry of a + b + cin.
module add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one ripple chain of add
// slices per iteration, WIDTH iterations per product, valid/ready both ends.
module shift_add_mult
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;

    logic [NIB:0]     carry;
    logic [WIDTH-1:0] add_sum;
    logic             c;
    logic [WIDTH-1:0] sum;

    assign carry[0] = 1'b0;

    // Nibble slices ripple their carries from LSB to MSB within one cycle
    for (genvar g = 0; g < NIB; g++) begin : g_chain
        add u_add (
            .a    (hi[4*g +: 4]),
            .b    (mcand[4*g +: 4]),
            .cin  (carry[g]),
            .sum  (add_sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    assign c   = lo[0] ? carry[NIB] : 1'b0;
    assign sum = lo[0] ? add_sum : hi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The adder carry lands in the top bit of hi, so nothing is lost
                    {hi, lo} <= {c, sum, lo[WIDTH-1:1]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= {c, sum, lo[WIDTH-1:1]};
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready  = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign busy         = (state == ST_RUN) || (state == ST_DONE);

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned shift-and-add multiplier for the ArithmeticOps group. It consumes the sum/carry output of the existing `add` block, using one ripple chain of `add` instances per iteration. Each transaction takes two WIDTH-bit operands over a valid/ready handshake and returns a 2·WIDTH-bit product after WIDTH iteration cycles. It is the first multi-cycle arithmetic stage built on top of `add`.

## Interface
- WIDTH, 4, operand width in bits; must be a positive multiple of 4 (one `add` instance per nibble).
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start_valid  in  1  operands a/b valid
- start_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- busy  out  1  high in RUN and DONE
- result_valid  out  1  product valid (high only in DONE)
- result_ready  in  1  consumer accepts product
- product  out  2·WIDTH  unsigned a×b

## Operation
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready at an edge, latch:
    - mcand←a
    - lo←b
    - hi←0
    - cnt←0
    - go to RUN.
  - RUN: one iteration per edge.
    - If lo[0]=1: {c,sum}=hi+mcand via the `add` chain, with cin of the LSB instance=0 and cout of each nibble feeding cin of the next. Otherwise {c,sum}={0,hi}.
    - Shift right: {hi,lo}←{c,sum,lo[WIDTH-1:1]}.
    - cnt←cnt+1.
    - When the iteration just done is the WIDTH-th (cnt==WIDTH-1): product←{c,sum,lo[WIDTH-1:1]} and go to DONE.
  - DONE: result_valid=1. On result_ready go to IDLE. Otherwise hold; product is stable.
- Arithmetic:
  - Unsigned only.
  - The carry out of the top nibble is never lost; it becomes bit WIDTH-1 of hi after the shift.
  - The final product fits exactly in 2·WIDTH bits; no overflow flag.
- Operands are sampled only at acceptance. Changes on a/b after that are ignored.
- start_valid outside IDLE is ignored. start_ready is low, so no transaction is accepted.
- product holds its last value through IDLE until overwritten on the next DONE entry.
- Reset values: state=IDLE, start_ready=1, busy=0, result_valid=0, product=0, internal registers=0.
- Reset mid-RUN or mid-DONE: the transaction is abandoned, and the outputs take their reset values on the next edge.

## Timing
- Acceptance edge E0. RUN iterations occur on edges E1..E_WIDTH. result_valid is high from edge E_WIDTH.
- WIDTH=4: result_valid is visible in the cycle after the 4th edge following acceptance.
- DONE lasts one cycle minimum when result_ready is held high; otherwise DONE holds indefinitely.
- IDLE→accept needs one cycle after DONE exits. Minimum initiation interval is WIDTH+2 cycles.
- No combinational path from start_valid or result_ready to any output except via registered state. start_ready and result_valid are decoded from the state register only.
- The `add` chain is combinational inside one cycle. No pipelining inside RUN.

## Structure
- Shared package `arith_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default ARITH_WIDTH=4
  - function for the counter width, clog2(WIDTH)
- Sub-module: the existing `add` (4-bit a, b, cin → sum, cout), instantiated WIDTH/4 times in a generate loop to form the ripple adder. No new sub-module.
- All state in one always block on posedge clk, with the rst_n check first.

## Test plan
- Reset with rst_n=0 for 2 cycles → start_ready=1, busy=0, result_valid=0, product=8'h00.
- WIDTH=4, a=6, b=3, result_ready=1 → result_valid exactly 4 edges after acceptance, product=8'h12, then start_ready=1 on the following cycle.
- Corner operands:
  - a=15, b=15 → product=8'hE1 (carry from top nibble propagates)
  - a=0, b=9 → 8'h00
  - a=1, b=15 → 8'h0F
- Back-pressure: a=6, b=3 with result_ready=0 for 5 cycles after result_valid → product stays 8'h12, busy=1 throughout; exits DONE one edge after result_ready=1.
- Operand change and extra start: change a/b and pulse start_valid during RUN → start_ready=0, the change is ignored, and the original product is still returned.
- Reset mid-op: rst_n=0 at RUN iteration 2 → next edge gives IDLE, product=0, result_valid=0. A fresh a=5, b=5 then yields 8'h19.
